// File: rtl/counter_m_monitor.sv
// Consumer-side checker for a mod-M counter: locks onto the observed sequence, then flags and counts deviations and wraps.
// Optional first-error capture outputs are built when COUNTER_M_MON_FIRST_ERR_EN is defined.
module counter_m_monitor #(
  parameter int M        = 10,
  parameter int WIDTH    = 4,
  parameter int ERR_W    = 8,
  parameter int SYNC_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  input  logic             carry_in,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [WIDTH-1:0] expected
`ifdef COUNTER_M_MON_FIRST_ERR_EN
  ,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_value
`endif
);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_SYNC     = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;

  localparam int               MATCH_W  = $clog2(SYNC_LEN + 1);
  localparam logic [MATCH_W-1:0] SYNC_TGT = MATCH_W'(SYNC_LEN);
  localparam logic [WIDTH-1:0] LAST     = WIDTH'(M - 1);
  localparam logic [ERR_W-1:0] SAT      = '1;

  logic [1:0]         state;
  logic [MATCH_W-1:0] match_cnt;
  logic [MATCH_W-1:0] match_inc;
  logic               sample_ok;
  logic               hit;
  logic [WIDTH-1:0]   prediction;

  // Explicit compare against M-1 so a modulus below 2**WIDTH never relies on overflow.
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] c, input logic e);
    if (!e)
      return c;
    if (c == LAST)
      return '0;
    return c + WIDTH'(1);
  endfunction

  // Comparing against LAST rather than M keeps the check correct when M == 2**WIDTH.
  assign sample_ok  = (count_in <= LAST) && (carry_in == (count_in == LAST));
  assign hit        = sample_ok && (count_in == expected);
  assign prediction = next_count(count_in, enable);
  assign match_inc  = match_cnt + MATCH_W'(1);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_UNLOCKED;
      match_cnt  <= '0;
      locked     <= 1'b0;
      error      <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      expected   <= '0;
`ifdef COUNTER_M_MON_FIRST_ERR_EN
      first_err_valid <= 1'b0;
      first_err_value <= '0;
`endif
    end else begin
      error <= 1'b0;
      case (state)
        S_UNLOCKED: begin
          if (sample_ok) begin
            expected  <= prediction;
            match_cnt <= '0;
            state     <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (hit) begin
            expected  <= prediction;
            match_cnt <= match_inc;
            if (match_inc == SYNC_TGT) begin
              state  <= S_LOCKED;
              locked <= 1'b1;
            end
          end else begin
            state <= S_UNLOCKED;
          end
        end
        S_LOCKED: begin
          if (hit) begin
            expected <= prediction;
            if (enable && (count_in == LAST) && (wrap_count != SAT))
              wrap_count <= wrap_count + ERR_W'(1);
          end else begin
            // The offending sample is discarded; resync starts on the next cycle.
            error  <= 1'b1;
            locked <= 1'b0;
            state  <= S_UNLOCKED;
            if (err_count != SAT)
              err_count <= err_count + ERR_W'(1);
`ifdef COUNTER_M_MON_FIRST_ERR_EN
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_value <= count_in;
            end
`endif
          end
        end
        default: begin
          state  <= S_UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_m_monitor.sv
// Scoreboard bench for counter_m_monitor: directed counter streams with hand-derived expectations,
// checked on a default instance and on an ERR_W=2 instance for saturation.
module tb_counter_m_monitor;

  localparam int M     = 10;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] count_in;
  logic             carry_in;

  logic             locked,     locked_s;
  logic             error,      error_s;
  logic [7:0]       err_count,  wrap_count;
  logic [1:0]       err_count_s, wrap_count_s;
  logic [WIDTH-1:0] expected,   expected_s;
`ifdef COUNTER_M_MON_FIRST_ERR_EN
  logic             first_err_valid,  first_err_valid_s;
  logic [WIDTH-1:0] first_err_value,  first_err_value_s;
`endif

  always #5 clk = ~clk;

  counter_m_monitor #(.M(M), .WIDTH(WIDTH), .ERR_W(8), .SYNC_LEN(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .count_in   (count_in),
    .carry_in   (carry_in),
    .locked     (locked),
    .error      (error),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .expected   (expected)
`ifdef COUNTER_M_MON_FIRST_ERR_EN
    ,
    .first_err_valid (first_err_valid),
    .first_err_value (first_err_value)
`endif
  );

  counter_m_monitor #(.M(M), .WIDTH(WIDTH), .ERR_W(2), .SYNC_LEN(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .count_in   (count_in),
    .carry_in   (carry_in),
    .locked     (locked_s),
    .error      (error_s),
    .err_count  (err_count_s),
    .wrap_count (wrap_count_s),
    .expected   (expected_s)
`ifdef COUNTER_M_MON_FIRST_ERR_EN
    ,
    .first_err_valid (first_err_valid_s),
    .first_err_value (first_err_value_s)
`endif
  );

  typedef struct {
    logic       locked;
    logic       error;
    int         err;
    int         wrap;
    int         exp;      // -1: value not defined for this cycle
    logic       fev;
    logic [3:0] fval;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Running expectations that only change at hand-chosen points in the stimulus.
  int         e_err;
  int         e_wrap;
  logic       e_fev;
  logic [3:0] e_fval;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
    end
  endtask

  function automatic int sat2(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Drive one cycle, then queue the outputs required right after this edge.
  task automatic step(input logic r, input logic en, input int c, input logic ca,
                      input logic x_locked, input logic x_error, input int x_exp);
    exp_t e;
    reset    = r;
    enable   = en;
    count_in = WIDTH'(c);
    carry_in = ca;
    @(posedge clk);
    e.locked = x_locked;
    e.error  = x_error;
    e.err    = e_err;
    e.wrap   = e_wrap;
    e.exp    = x_exp;
    e.fev    = e_fev;
    e.fval   = e_fval;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic good(input logic en, input int c, input logic x_locked, input int x_exp);
    step(1'b0, en, c, (c == M - 1), x_locked, 1'b0, x_exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("locked", locked, e.locked);
        check("error", error, e.error);
        check("err_count", err_count, e.err);
        check("wrap_count", wrap_count, e.wrap);
        check("locked_sat", locked_s, e.locked);
        check("error_sat", error_s, e.error);
        check("err_count_sat", err_count_s, sat2(e.err));
        check("wrap_count_sat", wrap_count_s, sat2(e.wrap));
        if (e.exp >= 0) begin
          check("expected", expected, e.exp);
          check("expected_sat", expected_s, e.exp);
        end
`ifdef COUNTER_M_MON_FIRST_ERR_EN
        check("first_err_valid", first_err_valid, e.fev);
        check("first_err_value", first_err_value, e.fval);
        check("first_err_valid_sat", first_err_valid_s, e.fev);
        check("first_err_value_sat", first_err_value_s, e.fval);
`endif
      end
    end
  end

  initial begin : stimulus
    int c;
    int r;
    reset = 1'b1; enable = 1'b0; count_in = '0; carry_in = 1'b0;
    e_err = 0; e_wrap = 0; e_fev = 1'b0; e_fval = '0;

    // 1: reset, then a clean counter; lock after the third sample, three wraps.
    repeat (10) step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 1; k <= 31; k++) begin
      c = (k - 1) % 10;
      if (k >= 4 && c == 9) e_wrap++;
      good(1'b1, c, (k >= 3), (c + 1) % 10);
    end

    // 2: enable 1,0,0,1 with the counter stalled during the zeros.
    good(1'b1, 1, 1'b1, 2);
    good(1'b0, 2, 1'b1, 2);
    good(1'b0, 2, 1'b1, 2);
    good(1'b1, 2, 1'b1, 3);
    good(1'b1, 3, 1'b1, 4);
    good(1'b1, 4, 1'b1, 5);

    // 3: glitch to 7 in place of 6, then relock on 7,8,9.
    good(1'b1, 5, 1'b1, 6);
    e_err = 1; e_fev = 1'b1; e_fval = 4'd7;
    step(1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b1, -1);
    good(1'b1, 7, 1'b0, 8);
    good(1'b1, 8, 1'b0, 9);
    good(1'b1, 9, 1'b1, 0);
    good(1'b1, 0, 1'b1, 1);
    good(1'b1, 1, 1'b1, 2);
    good(1'b1, 2, 1'b1, 3);
    good(1'b1, 3, 1'b1, 4);

    // 4: bad carry at count 4, then out-of-range 12 while unlocked.
    e_err = 2;
    step(1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1, -1);
    repeat (3) step(1'b0, 1'b1, 12, 1'b0, 1'b0, 1'b0, -1);
    good(1'b1, 8, 1'b0, 9);
    good(1'b1, 9, 1'b0, 0);
    good(1'b1, 0, 1'b1, 1);
    for (int v = 1; v <= 5; v++) good(1'b1, v, 1'b1, v + 1);

    // 5: one-cycle reset at count 6; everything clears and relocks from 0.
    e_err = 0; e_wrap = 0; e_fev = 1'b0; e_fval = '0;
    step(1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 1; k <= 5; k++) good(1'b1, k - 1, (k >= 3), k);

    // 6: five errors with relock between; the ERR_W=2 copy saturates at 3.
    r = 5;
    for (int i = 0; i < 5; i++) begin
      e_err++;
      if (i == 0) begin
        e_fev = 1'b1; e_fval = 4'd3;
        step(1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, -1);
      end else begin
        step(1'b0, 1'b1, 11, 1'b0, 1'b0, 1'b1, -1);
      end
      good(1'b1, (r + 1) % 10, 1'b0, (r + 2) % 10);
      good(1'b1, (r + 2) % 10, 1'b0, (r + 3) % 10);
      good(1'b1, (r + 3) % 10, 1'b1, (r + 4) % 10);
      if ((r + 4) % 10 == 9) e_wrap++;
      good(1'b1, (r + 4) % 10, 1'b1, (r + 5) % 10);
      r = (r + 5) % 10;
    end

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
